// File: rtl/collision_ctrl.sv
// Frame-rate collision controller: detects ball/spike and ball/platform contact and
// sequences the DEAD -> GRACE -> PLAY level-reset cycle, death counter and landing floor.
module collision_ctrl #(
  parameter int GROUND       = 479,
  parameter int DEAD_FRAMES  = 30,
  parameter int GRACE_FRAMES = 2,
  parameter int LAND_TOL     = 6
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic signed [64:0] ballX,
  input  logic signed [64:0] ballY,
  input  logic signed [64:0] ballS,
  input  logic signed [64:0] spikeX,
  input  logic signed [64:0] spikeY,
  input  logic signed [64:0] spikeS,
  input  logic signed [64:0] pfX,
  input  logic signed [64:0] pfY,
  input  logic signed [64:0] pfS,
  output logic               game_rst,
  output logic [9:0]         ball_floor,
  output logic [7:0]         attempts,
  output logic               dead
);

  localparam logic [1:0] S_DEAD  = 2'd0;
  localparam logic [1:0] S_GRACE = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;

  localparam int                     CNT_W      = 16;
  localparam logic [CNT_W-1:0]       DEAD_LOAD  = CNT_W'(DEAD_FRAMES - 1);
  localparam logic [CNT_W-1:0]       GRACE_LOAD = CNT_W'((GRACE_FRAMES > 0) ? GRACE_FRAMES - 1 : 0);
  localparam logic [9:0]             GROUND_Y   = 10'(GROUND);
  localparam logic signed [64:0]     TOL        = 65'(LAND_TOL);
  localparam logic signed [64:0]     ONE        = 65'sd1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             game_rst_q, game_rst_d;
  logic             dead_q, dead_d;
  logic [7:0]       attempts_q, attempts_d;
  logic [9:0]       floor_q, floor_d;

  // Ball box is centre +/- half-size; object boxes are top-left + side - 1, all inclusive.
  logic signed [64:0] ball_l, ball_r, ball_t, ball_b;
  logic signed [64:0] spike_r, spike_b, pf_r, pf_b;
  logic spike_x, spike_y, pf_x, pf_y;
  logic spike_hit, pf_land, pf_side;

  assign ball_l  = ballX - ballS;
  assign ball_r  = ballX + ballS;
  assign ball_t  = ballY - ballS;
  assign ball_b  = ballY + ballS;
  assign spike_r = spikeX + spikeS - ONE;
  assign spike_b = spikeY + spikeS - ONE;
  assign pf_r    = pfX + pfS - ONE;
  assign pf_b    = pfY + pfS - ONE;

  assign spike_x   = (ball_l <= spike_r) && (spikeX <= ball_r);
  assign spike_y   = (ball_t <= spike_b) && (spikeY <= ball_b);
  assign pf_x      = (ball_l <= pf_r) && (pfX <= ball_r);
  assign pf_y      = (ball_t <= pf_b) && (pfY <= ball_b);
  assign spike_hit = spike_x && spike_y;
  assign pf_land   = pf_x && (ball_b >= pfY - TOL) && (ball_b <= pfY + TOL);
  assign pf_side   = pf_x && pf_y && !pf_land;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    game_rst_d = game_rst_q;
    dead_d     = dead_q;
    attempts_d = attempts_q;
    floor_d    = GROUND_Y;
    case (state_q)
      S_DEAD: begin
        if (cnt_q == '0) begin
          game_rst_d = 1'b0;
          dead_d     = 1'b0;
          if (GRACE_FRAMES == 0) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            state_d = S_GRACE;
            cnt_d   = GRACE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GRACE: begin
        if (cnt_q == '0) state_d = S_PLAY;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_PLAY: begin
        // Death outranks landing: the floor drops back to ground on the fatal frame.
        if (spike_hit || pf_side) begin
          state_d    = S_DEAD;
          cnt_d      = DEAD_LOAD;
          game_rst_d = 1'b1;
          dead_d     = 1'b1;
          attempts_d = (attempts_q == 8'hFF) ? attempts_q : attempts_q + 8'd1;
        end else if (pf_land) begin
          floor_d = pfY[9:0];
        end
      end
      default: begin
        state_d    = S_DEAD;
        cnt_d      = DEAD_LOAD;
        game_rst_d = 1'b1;
        dead_d     = 1'b1;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments; Reset is asynchronous and lands in DEAD so movers restart.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_DEAD;
      cnt_q      <= DEAD_LOAD;
      game_rst_q <= 1'b1;
      dead_q     <= 1'b1;
      attempts_q <= 8'd0;
      floor_q    <= GROUND_Y;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      game_rst_q <= game_rst_d;
      dead_q     <= dead_d;
      attempts_q <= attempts_d;
      floor_q    <= floor_d;
    end
  end

  assign game_rst   = game_rst_q;
  assign dead       = dead_q;
  assign attempts   = attempts_q;
  assign ball_floor = floor_q;

endmodule

// File: tb/tb_collision_ctrl.sv
// Scoreboard bench for collision_ctrl: the driver queues expected outputs per frame,
// a negedge monitor pops and compares them against the DUT.
module tb_collision_ctrl;

  logic               frame_clk;
  logic               Reset;
  logic signed [64:0] ballX, ballY, ballS;
  logic signed [64:0] spikeX, spikeY, spikeS;
  logic signed [64:0] pfX, pfY, pfS;
  logic               game_rst;
  logic [9:0]         ball_floor;
  logic [7:0]         attempts;
  logic               dead;

  collision_ctrl dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .ballX      (ballX),
    .ballY      (ballY),
    .ballS      (ballS),
    .spikeX     (spikeX),
    .spikeY     (spikeY),
    .spikeS     (spikeS),
    .pfX        (pfX),
    .pfY        (pfY),
    .pfS        (pfS),
    .game_rst   (game_rst),
    .ball_floor (ball_floor),
    .attempts   (attempts),
    .dead       (dead)
  );

  typedef struct {
    logic       grst;
    logic       dd;
    logic [7:0] att;
    logic [9:0] flr;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge frame_clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.tag, ".game_rst"},   16'(game_rst),   16'(mon_e.grst));
      check({mon_e.tag, ".dead"},       16'(dead),       16'(mon_e.dd));
      check({mon_e.tag, ".attempts"},   16'(attempts),   16'(mon_e.att));
      check({mon_e.tag, ".ball_floor"}, 16'(ball_floor), 16'(mon_e.flr));
    end
  end

  task automatic push(input logic g, input logic d, input logic [7:0] a,
                      input logic [9:0] f, input string tag);
    exp_t e;
    e.grst = g;
    e.dd   = d;
    e.att  = a;
    e.flr  = f;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic g, input logic d, input logic [7:0] a,
                      input logic [9:0] f, input string tag);
    @(posedge frame_clk);
    #1;
    push(g, d, a, f, tag);
  endtask

  // Skips one edge, then raises Reset between edges so only the asynchronous path can show it.
  task automatic do_reset(input string tag);
    @(posedge frame_clk);
    #1 Reset = 1'b1;
    #1 push(1'b1, 1'b1, 8'd0, 10'd479, tag);
    @(posedge frame_clk);
    #1 Reset = 1'b0;
  endtask

  // From DEAD entry (counter 29): 29 more edges held, the 30th edge drops into GRACE.
  task automatic hold(input logic [7:0] a);
    for (int i = 1; i < 30; i++) tick(1'b1, 1'b1, a, 10'd479, "dead_hold");
    tick(1'b0, 1'b0, a, 10'd479, "dead_exit");
  endtask

  task automatic grace(input logic [7:0] a);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, a, 10'd479, "grace");
  endtask

  task automatic set_ball(input longint x, input longint y, input longint s);
    ballX = 65'(x); ballY = 65'(y); ballS = 65'(s);
  endtask

  task automatic set_spike(input longint x, input longint y, input longint s);
    spikeX = 65'(x); spikeY = 65'(y); spikeS = 65'(s);
  endtask

  task automatic set_pf(input longint x, input longint y, input longint s);
    pfX = 65'(x); pfY = 65'(y); pfS = 65'(s);
  endtask

  logic [7:0] a;

  initial begin
    Reset = 1'b1;
    set_ball(100, 464, 15);
    set_spike(-40, 447, 40);
    set_pf(600, 397, 28);

    // Power-on reset, full countdown, grace, then PLAY with a spike scrolled off to the left.
    do_reset("por");
    hold(8'd0);
    grace(8'd0);
    tick(1'b0, 1'b0, 8'd0, 10'd479, "play_idle_negx");

    // Landing on a platform, then the platform moves away.
    set_ball(200, 380, 15);
    set_pf(190, 397, 28);
    tick(1'b0, 1'b0, 8'd0, 10'd397, "land");
    tick(1'b0, 1'b0, 8'd0, 10'd397, "land_hold");
    set_pf(300, 397, 28);
    tick(1'b0, 1'b0, 8'd0, 10'd479, "land_leave");

    // Side impact on a platform kills.
    set_pf(190, 390, 28);
    set_ball(200, 420, 15);
    tick(1'b1, 1'b1, 8'd1, 10'd479, "pf_side");
    set_pf(600, 397, 28);
    hold(8'd1);

    // Spike present through GRACE is ignored, then kills on the first PLAY edge.
    set_ball(100, 464, 15);
    set_spike(110, 447, 32);
    grace(8'd1);
    tick(1'b1, 1'b1, 8'd2, 10'd479, "spike_after_grace");
    set_spike(-100, 447, 32);
    hold(8'd2);
    grace(8'd2);

    // Spike and landing in the same frame: death wins, floor stays at ground through recovery.
    set_ball(200, 380, 15);
    set_pf(190, 397, 28);
    set_spike(210, 370, 20);
    tick(1'b1, 1'b1, 8'd3, 10'd479, "spike_vs_land");
    set_spike(-100, 447, 32);
    hold(8'd3);
    grace(8'd3);
    tick(1'b0, 1'b0, 8'd3, 10'd397, "land_after_grace");

    // Edge pixels: one pixel apart is clear, a shared pixel column overlaps.
    set_pf(600, 397, 28);
    set_spike(216, 380, 10);
    tick(1'b0, 1'b0, 8'd3, 10'd479, "edge_gap");
    set_spike(215, 380, 10);
    tick(1'b1, 1'b1, 8'd4, 10'd479, "edge_touch");
    hold(8'd4);
    grace(8'd4);

    // Repeated deaths with the spike left in place: attempts saturates at 255.
    a = 8'd4;
    for (int k = 0; k < 252; k++) begin
      a = (a == 8'd255) ? 8'd255 : a + 8'd1;
      tick(1'b1, 1'b1, a, 10'd479, "sat_death");
      hold(a);
      grace(a);
    end
    tick(1'b1, 1'b1, 8'd255, 10'd479, "sat_extra");

    // Reset in the middle of DEAD at counter 10 restarts the full hold and clears attempts.
    for (int i = 0; i < 18; i++) tick(1'b1, 1'b1, 8'd255, 10'd479, "pre_rst_dead");
    do_reset("rst_mid_dead");
    set_spike(-100, 447, 32);
    hold(8'd0);
    grace(8'd0);

    // Reset during PLAY while landed pulls everything back immediately.
    set_ball(200, 380, 15);
    set_pf(190, 397, 28);
    tick(1'b0, 1'b0, 8'd0, 10'd397, "land_before_rst");
    do_reset("rst_mid_play");
    hold(8'd0);
    grace(8'd0);
    tick(1'b0, 1'b0, 8'd0, 10'd397, "land_after_rst");

    repeat (4) @(posedge frame_clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
